nbit_register_file_mp: RTL
==========================

// Module: nbit_register_file_mp
// PURPOSE
//  Parametrised successor to the CPU's 2-read/1-write register file. It adds:
//  - N combinational read ports.
//  - Optional hardwired-zero register 0.
//  - Optional write-to-read bypass.
//  - A sequential clear engine that zeroes every entry, one per cycle, after reset or on request.
//  Sits in the datapath decode stage; read outputs feed the ALU operand muxes.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  ADDR_WIDTH  5   address bits; DEPTH = 2**ADDR_WIDTH entries
//  NUM_READ    2   number of read ports (>=1)
//  ZERO_REG    1   1: entry 0 always reads 0 and writes to it are dropped
//  BYPASS      1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk         in   1                      rising-edge clock
//  rst         in   1                      synchronous, active-high reset
//  clr_req     in   1                      pulse: start a full clear (honoured only in RUN)
//  RegWrite    in   1                      write enable
//  write_address in ADDR_WIDTH             write index
//  write_data  in   DATA_WIDTH             write value
//  read_sel    in   NUM_READ*ADDR_WIDTH    packed read indices; port k = [k*AW +: AW]
//  read_data   out  NUM_READ*DATA_WIDTH    packed read values; port k = [k*DW +: DW]
//  busy        out  1                      1 while the clear engine runs; writes ignored
// BEHAVIOUR
//  FSM states: CLEAR, RUN. Registered counter clr_idx[ADDR_WIDTH-1:0].
//  Reset:
//   - Any posedge with rst=1: state<=CLEAR, clr_idx<=0, busy<=1.
//   - rst dominates clr_req and RegWrite.
//   - Array contents are not reset directly; they are undefined at power-up.
//  CLEAR state:
//   - Each posedge with rst=0: entry[clr_idx]<=0, clr_idx<=clr_idx+1.
//   - On the edge that clears DEPTH-1: state<=RUN, busy<=0, clr_idx wraps to 0.
//   - busy is therefore high for exactly DEPTH cycles after rst falls.
//   - RegWrite is ignored; no write is queued.
//   - clr_req is ignored (it does not restart the count).
//   - rst=1 mid-clear restarts the clear at index 0.
//   - All read_data ports are forced to 0.
//  RUN state:
//   - Posedge with RegWrite=1: entry[write_address]<=write_data.
//   - If ZERO_REG=1 and write_address==0, the write is dropped.
//   - clr_req=1 on a posedge: state<=CLEAR, clr_idx<=0, busy<=1.
//   - A RegWrite in that same cycle is still performed; it is then overwritten by the clear.
//  Reads (combinational, zero latency, evaluated per port k independently):
//   - If busy: 0.
//   - Else if ZERO_REG and sel==0: 0.
//   - Else if BYPASS and RegWrite and write_address==sel: write_data.
//   - Else: entry[sel].
//   - With BYPASS=0 a read returns the old value until the edge after the write.
//  Any number of ports may address the same entry; no arbitration is needed.
//  Widths: read_sel/read_data are packed and unsigned; no arithmetic beyond clr_idx+1 mod DEPTH.
//  busy is a registered output with no combinational path from inputs.
// TESTING (defaults, DEPTH=32, NUM_READ=2)
//  1 Reset/clear:
//    - Stimulus: rst=1 for 2 cycles, then 0; RegWrite=1 to addr 5 held throughout.
//    - Response: busy=1 for exactly 32 cycles after rst falls; all reads 0;
//      after busy falls, addr 5 reads 0.
//  2 Write/read:
//    - Stimulus: write 0xDEADBEEF to addr 7; next cycle read_sel={7,7}.
//    - Response: both ports read 0xDEADBEEF.
//  3 Bypass:
//    - Stimulus: same cycle, write 0x1234 to addr 3 with port0 sel=3.
//    - Response: port0=0x1234 before the edge.
//    - Repeat with BYPASS=0: port0 shows the old value, then 0x1234 after the edge.
//  4 Zero register:
//    - Stimulus: write 0xFFFFFFFF to addr 0; read addr 0 on both ports.
//    - Response: 0 on both, including with a same-cycle bypass attempt.
//  5 Clear request mid-run:
//    - Stimulus: fill addrs 1..31 with their index; pulse clr_req at cycle T; pulse clr_req again at T+10.
//    - Response: busy from T+1 through T+32; all entries 0 afterward; the second pulse is ignored.
//  6 Reset mid-clear:
//    - Stimulus: assert rst for 1 cycle at clear index 20.
//    - Response: clear restarts at index 0; busy remains high for 32 more cycles after rst falls.

Source files
------------

// File: rtl/nbit_register_file_mp.sv
// Multi-read-port register file with optional zero register, write bypass,
// and a one-entry-per-cycle clear engine run after reset or on request.
module nbit_register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr_req,
    input  logic                           RegWrite,
    input  logic [ADDR_WIDTH-1:0]          write_address,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_sel,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic                           busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = write_address;
        mem_wdata = write_data;
        if (rst) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_idx_q;
                    mem_wdata = '0;
                    clr_idx_d = clr_idx_q + 1'b1;
                    if (clr_idx_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    // Entry 0 is never written when it is the hardwired zero.
                    mem_we = RegWrite &&
                             !(ZERO_REG && (write_address == '0));
                    if (clr_req) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        busy_q    <= busy_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy = busy_q;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] sel;
        logic [DATA_WIDTH-1:0] val;

        assign sel = read_sel[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            val = mem_q[sel];
            if (busy_q) begin
                val = '0;
            end else if (ZERO_REG && (sel == '0)) begin
                val = '0;
            end else if (BYPASS && RegWrite && (write_address == sel)) begin
                val = write_data;
            end
        end

        assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = val;
    end

endmodule
